// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - two-entry MEM/WB pipeline skid register with forwarding tap
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic              wbEnIn,
    input  logic              memReadEnIn,
    input  logic [DATA_W-1:0] aluResultIn,
    input  logic [DATA_W-1:0] memReadValueIn,
    input  logic [DST_W-1:0]  dstIn,
    output logic              outValid,
    input  logic              outReady,
    output logic              wbEn,
    output logic              memReadEn,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] memReadValue,
    output logic [DST_W-1:0]  dst,
    output logic              fwdValid,
    output logic [DST_W-1:0]  fwdDst,
    output logic [DATA_W-1:0] fwdValue,
    output logic [1:0]        occupancy
);

    localparam int ENTRY_W = 2 + 2 * DATA_W + DST_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    typedef enum logic [1:0] {H_HOLD, H_IN, H_SKID, H_CLR} head_op_t;
    typedef enum logic [1:0] {S_HOLD, S_IN, S_CLR} skid_op_t;

    state_t             state_q;
    state_t             state_d;
    head_op_t           head_op;
    skid_op_t           skid_op;
    logic               accept;
    logic               consume;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] skid_q;
    logic [ENTRY_W-1:0] in_entry;
    logic               head_wb;
    logic               head_mr;

    assign in_entry = {wbEnIn, memReadEnIn, aluResultIn, memReadValueIn, dstIn};

    // Handshakes depend on registered state only, so inReady never sees outReady.
    assign accept  = inValid && (state_q != TWO);
    assign consume = (state_q != EMPTY) && outReady;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_op = H_HOLD;
        skid_op = S_HOLD;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_op = H_IN;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    head_op = H_IN;
                end else if (accept) begin
                    state_d = TWO;
                    skid_op = S_IN;
                end else if (consume) begin
                    state_d = EMPTY;
                    head_op = H_CLR;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                    head_op = H_SKID;
                    skid_op = S_CLR;
                end
            end
            default: begin
                state_d = EMPTY;
                head_op = H_CLR;
                skid_op = S_CLR;
            end
        endcase
    end

    always_comb begin
        outValid  = (state_q != EMPTY);
        inReady   = (state_q != TWO);
        occupancy = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            case (head_op)
                H_IN:    head_q <= in_entry;
                H_SKID:  head_q <= skid_q;
                H_CLR:   head_q <= '0;
                default: head_q <= head_q;
            endcase
            case (skid_op)
                S_IN:    skid_q <= in_entry;
                S_CLR:   skid_q <= '0;
                default: skid_q <= skid_q;
            endcase
        end
    end

    assign {head_wb, head_mr, aluResult, memReadValue, dst} = head_q;

    assign wbEn      = head_wb && outValid;
    assign memReadEn = head_mr;
    assign fwdValid  = outValid && head_wb;
    assign fwdDst    = dst;
    assign fwdValue  = head_mr ? memReadValue : aluResult;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb/tb_mem_wb_skid_reg.sv - self-checking bench for mem_wb_skid_reg
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, inReady;
    logic        wbEnIn, memReadEnIn;
    logic [31:0] aluResultIn, memReadValueIn;
    logic [3:0]  dstIn;
    logic        outValid, outReady;
    logic        wbEn, memReadEn;
    logic [31:0] aluResult, memReadValue;
    logic [3:0]  dst;
    logic        fwdValid;
    logic [3:0]  fwdDst;
    logic [31:0] fwdValue;
    logic [1:0]  occupancy;

    int passed = 0;
    int total  = 0;
    bit seen_33 = 1'b0;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mrv;
        logic [3:0]  dst;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mrv;
        logic [3:0]  dst;
        int          exp_occ;
        logic        chk_zero;
    } vec_t;

    ent_t q[$];

    mem_wb_skid_reg #(.DATA_W(32), .DST_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .wbEnIn(wbEnIn), .memReadEnIn(memReadEnIn),
        .aluResultIn(aluResultIn), .memReadValueIn(memReadValueIn), .dstIn(dstIn),
        .outValid(outValid), .outReady(outReady),
        .wbEn(wbEn), .memReadEn(memReadEn),
        .aluResult(aluResult), .memReadValue(memReadValue), .dst(dst),
        .fwdValid(fwdValid), .fwdDst(fwdDst), .fwdValue(fwdValue),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (outValid === 1'b1 && aluResult === 32'h33) seen_33 = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                                input logic wb, input logic mr, input logic [31:0] alu,
                                input logic [31:0] mrv, input logic [3:0] d, input int occ,
                                input logic z);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy;
        v.wb = wb; v.mr = mr; v.alu = alu; v.mrv = mrv; v.dst = d;
        v.exp_occ = occ; v.chk_zero = z;
        return v;
    endfunction

    task automatic check_head();
        ent_t e;
        check("outValid", outValid, q.size() > 0);
        check("inReady", inReady, q.size() < 2);
        check("occupancy", occupancy, q.size());
        if (q.size() > 0) begin
            e = q[0];
            check("aluResult", aluResult, e.alu);
            check("memReadValue", memReadValue, e.mrv);
            check("dst", dst, e.dst);
            check("memReadEn", memReadEn, e.mr);
            check("wbEn", wbEn, e.wb);
            check("fwdValid", fwdValid, e.wb);
            check("fwdDst", fwdDst, e.dst);
            check("fwdValue", fwdValue, e.mr ? e.mrv : e.alu);
        end else begin
            check("wbEn_empty", wbEn, 1'b0);
            check("fwdValid_empty", fwdValid, 1'b0);
        end
    endtask

    task automatic check_zero();
        check("z_outValid", outValid, 1'b0);
        check("z_inReady", inReady, 1'b1);
        check("z_wbEn", wbEn, 1'b0);
        check("z_memReadEn", memReadEn, 1'b0);
        check("z_aluResult", aluResult, 32'h0);
        check("z_memReadValue", memReadValue, 32'h0);
        check("z_dst", dst, 4'h0);
        check("z_fwdValid", fwdValid, 1'b0);
        check("z_fwdValue", fwdValue, 32'h0);
        check("z_occupancy", occupancy, 2'd0);
    endtask

    // Called just after a falling edge: check, drive, advance model, step one cycle.
    task automatic apply(input vec_t v);
        ent_t e;
        ent_t dump;
        bit   acc;
        bit   cons;
        check_head();
        rst = v.rst; flush = v.flush; inValid = v.in_valid; outReady = v.out_ready;
        wbEnIn = v.wb; memReadEnIn = v.mr; aluResultIn = v.alu;
        memReadValueIn = v.mrv; dstIn = v.dst;
        e.wb = v.wb; e.mr = v.mr; e.alu = v.alu; e.mrv = v.mrv; e.dst = v.dst;
        if (v.rst || v.flush) begin
            q.delete();
        end else begin
            cons = (q.size() > 0) && v.out_ready;
            acc  = v.in_valid && (q.size() < 2);
            if (cons) dump = q.pop_front();
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.exp_occ >= 0) check("exp_occ", occupancy, v.exp_occ[1:0]);
        if (v.chk_zero) check_zero();
        @(negedge clk);
    endtask

    vec_t tbl[18];
    vec_t v;

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        wbEnIn = 1'b0; memReadEnIn = 1'b0; aluResultIn = '0; memReadValueIn = '0; dstIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        //            rst flush iv ordy wb mr alu            mrv            dst   occ zero
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4'd0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 1, 1, 0, 32'h1234,     32'h0,        4'd5, 1, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 1, 0, 32'h11,       32'h0,        4'd1, 1, 0);
        tbl[4]  = mk(0, 0, 1, 0, 1, 0, 32'h22,       32'h0,        4'd2, 2, 0);
        tbl[5]  = mk(0, 0, 1, 0, 1, 0, 32'h99,       32'h0,        4'd9, 2, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4'd0, 2, 0);
        tbl[7]  = mk(0, 0, 1, 1, 1, 0, 32'h44,       32'h0,        4'd4, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 1, 1, 32'h55,       32'h5A5A,     4'd6, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 1, 1, 32'hAAAA,     32'h5555,     4'd7, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 1, 0, 32'h66,       32'h0,        4'd3, 2, 0);
        tbl[12] = mk(0, 1, 1, 1, 1, 0, 32'h33,       32'h0,        4'd8, 0, 1);
        tbl[13] = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 32'h77,       32'h0,        4'd2, 1, 0);
        tbl[15] = mk(0, 0, 1, 0, 1, 0, 32'h88,       32'h0,        4'd3, 2, 0);
        tbl[16] = mk(1, 1, 1, 1, 1, 1, 32'h99,       32'h9999,     4'd9, 0, 1);
        tbl[17] = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 1);

        for (int i = 0; i < 18; i++) begin
            if (i == 11) check("load_fwdValue", fwdValue, 32'h5555);
            apply(tbl[i]);
        end

        // Fill to TWO, hold under backpressure while upstream keeps offering, then drain in order.
        apply(mk(0, 0, 1, 0, 1, 0, 32'hA1, 32'h0, 4'd1, 1, 0));
        apply(mk(0, 0, 1, 0, 1, 0, 32'hA2, 32'h0, 4'd2, 2, 0));
        for (int i = 0; i < 20; i++)
            apply(mk(0, 0, 1, 0, 1, 1, 32'hB0 + i, 32'hC0 + i, 4'(i), 2, 0));
        check("hold_head", aluResult, 32'hA1);
        apply(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'd0, 1, 0));
        check("drain_second", aluResult, 32'hA2);
        apply(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0));

        // Randomised traffic against the queue scoreboard.
        for (int i = 0; i < 400; i++) begin
            v = mk(0, ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom | 32'h8000_0000,
                   $urandom | 32'h8000_0000, 4'($urandom), -1, 0);
            apply(v);
        end
        apply(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'd0, -1, 0));
        apply(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0));
        check_head();
        check("flushed_0x33_never_emitted", seen_33, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
MEM_WB_SKID_REG -- requirements
Module: mem_wb_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of aluResult and memReadValue.
REQ-002 The block SHALL have parameter DST_W, default 4, width of dst.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 The block SHALL have port inValid, input, 1, upstream entry present.
REQ-007 The block SHALL have port inReady, output, 1, block can accept an entry this cycle.
REQ-008 The block SHALL have ports wbEnIn, input, 1, and memReadEnIn, input, 1, incoming control bits.
REQ-009 The block SHALL have ports aluResultIn and memReadValueIn, input, DATA_W each, incoming data.
REQ-010 The block SHALL have port dstIn, input, DST_W, incoming destination register index.
REQ-011 The block SHALL have port outValid, output, 1, head entry present.
REQ-012 The block SHALL have port outReady, input, 1, downstream consumes the head entry this cycle.
REQ-013 The block SHALL have ports wbEn, memReadEn, aluResult, memReadValue and dst, outputs, widths as inputs, head entry fields.
REQ-014 The block SHALL have port fwdValid, output, 1, and port fwdDst, output, DST_W, forwarding-tap valid and index.
REQ-015 The block SHALL have port fwdValue, output, DATA_W, forwarding-tap data.
REQ-016 The block SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-017 The block SHALL hold at most two entries, a head register and a skid register, with states EMPTY (0), ONE (1) and TWO (2).
REQ-018 An entry SHALL be accepted when inValid && inReady; it SHALL be consumed when outValid && outReady.
REQ-019 inReady SHALL be 1 exactly when state != TWO, decoded from registered state only, with no combinational path from outReady.
REQ-020 outValid SHALL be 1 exactly when state != EMPTY; the head entry fields SHALL drive the outputs.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept+no consume->TWO; ONE+consume+no accept->EMPTY; ONE+accept+consume->ONE with the new entry in head; TWO+consume->ONE with skid moved to head; all other cases hold state.
REQ-022 Latency SHALL be one cycle: an entry accepted into an EMPTY block SHALL appear on the outputs in the next cycle.
REQ-023 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush or rst.
REQ-024 The wbEn output SHALL equal the stored wbEn AND outValid.
REQ-025 fwdValid SHALL equal outValid && wbEn; fwdDst SHALL equal dst.
REQ-026 fwdValue SHALL equal memReadValue when memReadEn=1, otherwise aluResult, computed combinationally from the head.
REQ-027 In TWO, head and skid contents SHALL be held unchanged while outReady=0, for any duration.
REQ-028 flush=1 SHALL force state EMPTY and zero all stored fields at the next edge, and SHALL take precedence over an accept or consume in the same cycle; the entry presented that cycle SHALL be discarded.
REQ-029 occupancy SHALL equal the state encoding.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL enter EMPTY and zero all stored fields; rst SHALL take precedence over flush, accept and consume.
REQ-031 After reset: outValid=0, inReady=1, wbEn=0, memReadEn=0, aluResult=0, memReadValue=0, dst=0, fwdValid=0, fwdValue=0, occupancy=0.
REQ-032 Reset asserted while in TWO SHALL discard both entries, with no entry appearing on the outputs afterwards.

Verification
REQ-033 Pass-through: outReady=1; push wbEnIn=1, memReadEnIn=0, aluResultIn=0x1234, dstIn=5 -> next cycle outValid=1, fwdValid=1, fwdDst=5, fwdValue=0x1234, occupancy=1.
REQ-034 Backpressure: outReady=0; push A=0x11 then B=0x22 -> occupancy=2, inReady=0, head=0x11; raise outReady -> 0x11 then 0x22 emitted in consecutive cycles.
REQ-035 Load select: push memReadEnIn=1, aluResultIn=0xAAAA, memReadValueIn=0x5555 -> fwdValue=0x5555.
REQ-036 Flush in TWO, with inValid=1 carrying 0x33 -> next cycle occupancy=0, outValid=0, all fields 0, and 0x33 never emitted.
REQ-037 Simultaneous: in ONE, accept and consume in the same cycle -> state ONE, head=new entry; in TWO, consume with inValid=1 -> the offered entry is not accepted (inReady=0).
REQ-038 Reset mid-operation: rst=1 in TWO with flush=1 and inValid=1 -> all outputs equal the REQ-031 values on the next cycle.
